// File: rtl/video_sync_if.sv
// Raster timing bundle between the sync generator and its consumers
// (video_mixer, pixel fetch, CPU interrupt logic).
interface video_sync_if;
   logic [8:0] line_cmp;
   logic       ce_pix;
   logic       HSync;
   logic       VSync;
   logic       HBlank;
   logic       VBlank;
   logic [9:0] hcnt;
   logic [8:0] vcnt;
   logic       int_n;
   logic       line_int;

   modport master (
      input  line_cmp,
      output ce_pix, HSync, VSync, HBlank, VBlank, hcnt, vcnt, int_n, line_int
   );

   modport slave (
      output line_cmp,
      input  ce_pix, HSync, VSync, HBlank, VBlank, hcnt, vcnt, int_n, line_int
   );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel clock enable, h/v counters, sync/blank decode,
// frame interrupt and programmable line interrupt.
module video_sync_gen #(
   parameter int CE_DIV   = 4,
   parameter int H_TOTAL  = 768,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 64,
   parameter int V_TOTAL  = 312,
   parameter int V_ACTIVE = 240,
   parameter int V_FP     = 24,
   parameter int V_SYNC   = 4,
   parameter int INT_LEN  = 128
) (
   input logic          clk_sys,
   input logic          reset,
   video_sync_if.master vid
);
   localparam int DW = $clog2(CE_DIV);
   localparam int IW = $clog2(INT_LEN + 1);
   // One bit wider than the counters so a sync ending exactly at the total does not wrap.
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div;
   logic          ce_pix;
   logic [9:0]    hcnt, h_nxt;
   logic [8:0]    vcnt, v_nxt;
   logic          hsync, vsync, hblank, vblank;
   logic          int_n, line_int;
   logic [IW-1:0] int_cnt;

   always_comb begin
      h_nxt = hcnt;
      v_nxt = vcnt;
      if (ce_pix) begin
         if (hcnt == 10'(H_TOTAL - 1)) begin
            h_nxt = '0;
            v_nxt = (vcnt == 9'(V_TOTAL - 1)) ? '0 : vcnt + 9'd1;
         end else begin
            h_nxt = hcnt + 10'd1;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         div      <= '0;
         ce_pix   <= 1'b0;
         hcnt     <= '0;
         vcnt     <= '0;
         hsync    <= 1'b0;
         vsync    <= 1'b0;
         hblank   <= 1'b0;
         vblank   <= 1'b0;
         int_n    <= 1'b1;
         int_cnt  <= '0;
         line_int <= 1'b0;
      end else begin
         div    <= (div == DW'(CE_DIV - 1)) ? '0 : div + 1'b1;
         ce_pix <= (div == DW'(CE_DIV - 1));
         hcnt   <= h_nxt;
         vcnt   <= v_nxt;
         // Decode next-state counters so outputs line up with hcnt/vcnt every cycle.
         hblank <= h_nxt >= 10'(H_ACTIVE);
         hsync  <= ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END);
         vblank <= v_nxt >= 9'(V_ACTIVE);
         vsync  <= ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END);

         if (ce_pix && h_nxt == '0 && v_nxt == 9'(V_ACTIVE)) begin
            int_n   <= 1'b0;
            int_cnt <= '0;
         end else if (ce_pix && !int_n) begin
            if (int_cnt == IW'(INT_LEN - 1)) int_n <= 1'b1;
            else                             int_cnt <= int_cnt + 1'b1;
         end

         line_int <= ce_pix && h_nxt == 10'(H_ACTIVE) && vcnt == vid.line_cmp &&
                     vid.line_cmp < 9'(V_ACTIVE);
      end
   end

   assign vid.ce_pix   = ce_pix;
   assign vid.hcnt     = hcnt;
   assign vid.vcnt     = vcnt;
   assign vid.HSync    = hsync;
   assign vid.VSync    = vsync;
   assign vid.HBlank   = hblank;
   assign vid.VBlank   = vblank;
   assign vid.int_n    = int_n;
   assign vid.line_int = line_int;
endmodule
